// File: rtl/aer_spike_encoder.sv
// Serialises per-cycle spike vectors into {address, timestamp} AER events; spike-to-valid is 2 cycles.
// Backpressure: a full FIFO stalls the scan, and new spikes accumulate in a merge buffer where collisions are counted.
module aer_spike_encoder #(
    parameter int NUM_NEURONS = 128,
    parameter int FIFO_DEPTH  = 16,
    parameter int TS_W        = 16,
    parameter int ADDR_W      = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_NEURONS-1:0] spikes_in,
    output logic                   aer_valid,
    input  logic                   aer_ready,
    output logic [ADDR_W-1:0]      aer_addr,
    output logic [TS_W-1:0]        aer_ts,
    output logic                   busy,
    output logic [15:0]            drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state_q, state_d;
    logic [NUM_NEURONS-1:0] frame_q, frame_d, next_q, next_d;
    logic [TS_W-1:0]        frame_ts_q, frame_ts_d, next_ts_q, next_ts_d, ts_q;
    logic                   next_vld_q, next_vld_d;
    logic [15:0]            drop_q, drop_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, after_pop;
    logic [ADDR_W-1:0]      head_addr_q, head_addr_d, low_idx;
    logic [TS_W-1:0]        head_ts_q, head_ts_d;
    logic [ADDR_W-1:0]      mem_addr [FIFO_DEPTH];
    logic [TS_W-1:0]        mem_ts   [FIFO_DEPTH];

    logic                   push, pop, fifo_full;
    logic [NUM_NEURONS-1:0] frame_left, collision;
    logic [16:0]            pc, drop_sum;

    // Scanning high-to-low leaves the lowest set index as the winner.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (frame_q[i]) low_idx = ADDR_W'(i);
        end
    end

    assign aer_valid  = (cnt_q != '0);
    assign busy       = (state_q == SCAN) || (cnt_q != '0);
    assign aer_addr   = head_addr_q;
    assign aer_ts     = head_ts_q;
    assign drop_count = drop_q;
    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop        = aer_valid && aer_ready;
    assign push       = (state_q == SCAN) && (frame_q != '0) && !fifo_full;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        frame_ts_d = frame_ts_q;
        next_d     = next_q;
        next_ts_d  = next_ts_q;
        next_vld_d = next_vld_q;
        collision  = '0;
        frame_left = frame_q;
        if (push) frame_left = frame_q & ~({{(NUM_NEURONS-1){1'b0}}, 1'b1} << low_idx);
        case (state_q)
            IDLE: begin
                if (spikes_in != '0) begin
                    frame_d    = spikes_in;
                    frame_ts_d = ts_q;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                frame_d = frame_left;
                if (frame_left == '0) begin
                    if (next_vld_q) begin
                        frame_d    = next_q;
                        frame_ts_d = next_ts_q;
                        next_d     = spikes_in;
                        next_vld_d = (spikes_in != '0);
                        next_ts_d  = ts_q;
                    end else if (spikes_in != '0) begin
                        frame_d    = spikes_in;
                        frame_ts_d = ts_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    collision = next_q & spikes_in;
                    next_d    = next_q | spikes_in;
                    if (!next_vld_q && spikes_in != '0) begin
                        next_ts_d  = ts_q;
                        next_vld_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        pc = '0;
        for (int i = 0; i < NUM_NEURONS; i++) pc = pc + 17'(collision[i]);
        drop_sum = {1'b0, drop_q} + pc;
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Head register tracks the oldest entry; it holds its value when the FIFO drains.
    always_comb begin
        cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
        after_pop   = cnt_q - CNT_W'(pop);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        head_addr_d = head_addr_q;
        head_ts_d   = head_ts_q;
        if (after_pop != '0) begin
            head_addr_d = mem_addr[rd_ptr_d];
            head_ts_d   = mem_ts[rd_ptr_d];
        end else if (push) begin
            head_addr_d = low_idx;
            head_ts_d   = frame_ts_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= low_idx;
            mem_ts[wr_ptr_q]   <= frame_ts_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            frame_ts_q  <= '0;
            next_q      <= '0;
            next_ts_q   <= '0;
            next_vld_q  <= 1'b0;
            ts_q        <= '0;
            drop_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            head_addr_q <= '0;
            head_ts_q   <= '0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            frame_ts_q  <= frame_ts_d;
            next_q      <= next_d;
            next_ts_q   <= next_ts_d;
            next_vld_q  <= next_vld_d;
            ts_q        <= ts_q + TS_W'(1);
            drop_q      <= drop_d;
            wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            head_addr_q <= head_addr_d;
            head_ts_q   <= head_ts_d;
        end
    end

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Randomised and directed checks of aer_spike_encoder against a queue-based event model.
module tb_aer_spike_encoder;

    localparam int N     = 128;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   spikes_in = '0;
    logic           aer_ready = 1'b0;
    logic           aer_valid;
    logic [6:0]     aer_addr;
    logic [15:0]    aer_ts;
    logic           busy;
    logic [15:0]    drop_count;

    aer_spike_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .spikes_in  (spikes_in),
        .aer_valid  (aer_valid),
        .aer_ready  (aer_ready),
        .aer_addr   (aer_addr),
        .aer_ts     (aer_ts),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame as an ordered address list, output FIFO as an event queue.
    typedef struct { int a; logic [15:0] t; } ev_t;
    int           fq[$];
    logic [15:0]  fts;
    logic [N-1:0] nvec;
    bit           nvld;
    logic [15:0]  nts;
    bit           scan;
    ev_t          mq[$];
    logic [15:0]  ts_m;
    int           drop_m;
    int           head_a;
    logic [15:0]  head_t;

    function automatic void load_frame(input logic [N-1:0] v);
        fq.delete();
        for (int i = 0; i < N; i++) if (v[i]) fq.push_back(i);
    endfunction

    function automatic void model_reset();
        fq.delete(); mq.delete();
        fts = '0; nvec = '0; nvld = 0; nts = '0; scan = 0;
        ts_m = '0; drop_m = 0; head_a = 0; head_t = '0;
    endfunction

    function automatic void model_step(input logic [N-1:0] spk, input logic rdy);
        bit   was_full;
        ev_t  e;
        was_full = (mq.size() >= DEPTH);
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (!scan) begin
            if (spk != '0) begin
                load_frame(spk); fts = ts_m; scan = 1;
            end
        end else begin
            if (fq.size() > 0 && !was_full) begin
                e.a = fq.pop_front(); e.t = fts;
                mq.push_back(e);
            end
            if (fq.size() == 0) begin
                if (nvld) begin
                    load_frame(nvec); fts = nts;
                    nvec = spk; nvld = (spk != '0); nts = ts_m;
                end else if (spk != '0) begin
                    load_frame(spk); fts = ts_m;
                end else begin
                    scan = 0;
                end
            end else begin
                for (int i = 0; i < N; i++) if (spk[i] && nvec[i] && drop_m < 65535) drop_m++;
                if (!nvld && spk != '0) begin nts = ts_m; nvld = 1; end
                nvec = nvec | spk;
            end
        end
        if (mq.size() > 0) begin head_a = mq[0].a; head_t = mq[0].t; end
        ts_m = ts_m + 16'd1;
    endfunction

    task automatic compare_all();
        chk("valid", 32'(aer_valid), 32'(mq.size() > 0));
        chk("addr",  32'(aer_addr),  32'(head_a));
        chk("ts",    32'(aer_ts),    32'(head_t));
        chk("busy",  32'(busy),      32'(scan || mq.size() > 0));
        chk("drop",  32'(drop_count), 32'(drop_m));
    endtask

    task automatic cyc(input logic [N-1:0] spk, input logic rdy);
        spikes_in = spk;
        aer_ready = rdy;
        @(posedge clk);
        model_step(spk, rdy);
        #1;
        compare_all();
    endtask

    function automatic logic [N-1:0] rand_spikes();
        logic [N-1:0] v;
        int r;
        v = '0;
        r = $urandom_range(0, 9);
        if (r < 3) begin
            repeat ($urandom_range(1, 4)) v[$urandom_range(0, N-1)] = 1'b1;
        end else if (r == 3) begin
            v = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom}
              & {$urandom, $urandom, $urandom, $urandom};
        end
        return v;
    endfunction

    logic [N-1:0] v;
    logic [N-1:0] one = 1;
    int rdy_pct;

    initial begin
        model_reset();
        #1;
        chk("rst_valid", 32'(aer_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_drop",  32'(drop_count), 32'd0);
        chk("rst_addr",  32'(aer_addr),  32'd0);
        chk("rst_ts",    32'(aer_ts),    32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;

        // single spike, latency and idle return
        cyc(one << 5, 1'b1);
        repeat (5) cyc('0, 1'b1);

        // three simultaneous spikes across the full address range
        cyc((one << 127) | (one << 3) | one, 1'b1);
        repeat (6) cyc('0, 1'b1);

        // 20-spike frame against a full FIFO
        v = '0;
        for (int i = 0; i < 20; i++) v[5*i+2] = 1'b1;
        cyc(v, 1'b0);
        repeat (24) cyc('0, 1'b0);
        repeat (25) cyc('0, 1'b1);
        chk("t3_drop", 32'(drop_count), 32'd0);

        // neuron 9 twice while the frame is stalled: one merge
        cyc(v, 1'b0);
        cyc('0, 1'b0);
        cyc(one << 9, 1'b0);
        cyc(one << 9, 1'b0);
        repeat (20) cyc('0, 1'b0);
        repeat (30) cyc('0, 1'b1);
        chk("t4_drop", 32'(drop_count), 32'd1);

        // randomised traffic with varying consumer throttle
        for (int s = 0; s < 15; s++) begin
            rdy_pct = $urandom_range(20, 100);
            for (int k = 0; k < 100; k++) cyc(rand_spikes(), 1'($urandom_range(1, 100) <= rdy_pct));
        end
        repeat (400) cyc('0, 1'b1);

        // timestamp wrap across consecutive spikes
        while (ts_m != 16'hFFFF) cyc('0, 1'b1);
        cyc(one << 1, 1'b1);
        cyc(one << 2, 1'b1);
        chk("wrap_addr", 32'(aer_addr), 32'd1);
        chk("wrap_ts",   32'(aer_ts),   32'hFFFF);
        cyc('0, 1'b1);
        chk("wrap2_addr", 32'(aer_addr), 32'd2);
        chk("wrap2_ts",   32'(aer_ts),   32'h0000);
        repeat (4) cyc('0, 1'b1);

        // reset while FIFO holds 8 events and the frame is still populated
        v = '0;
        for (int i = 0; i < 30; i++) v[4*i+1] = 1'b1;
        cyc(v, 1'b0);
        repeat (8) cyc('0, 1'b0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(aer_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_drop",  32'(drop_count), 32'd0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (10) cyc('0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
